// File: rtl/cnter_mod_nbit.sv
// Modulo-MOD up/down counter with synchronous clear/load, wrap or saturate at
// the boundaries, a cascadable terminal-count output and one-cycle OVF/ERR pulses.
module cnter_mod_nbit #(
  parameter int N   = 4,
  parameter int MOD = 10,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         RESET_N,
  input  logic         CLR,
  input  logic         LD,
  input  logic         EN,
  input  logic         UP,
  input  logic [N-1:0] DIN,
  output logic [N-1:0] COUNT,
  output logic         TC,
  output logic         OVF,
  output logic         ERR
);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("cnter_mod_nbit: N=%0d outside 2..16", N);
  end
  if (MOD < 2 || MOD > (1 << N)) begin : g_bad_mod
    $error("cnter_mod_nbit: MOD=%0d outside 2..2^N", MOD);
  end
  if (SAT != 0 && SAT != 1) begin : g_bad_sat
    $error("cnter_mod_nbit: SAT=%0d must be 0 or 1", SAT);
  end

  // Top count value held with one guard bit so MOD = 2^N compares cleanly.
  localparam logic [N:0] MAX_EXT = (N+1)'(MOD - 1);

  logic [N:0]   count_ext;
  logic [N:0]   din_ext;
  logic [N:0]   next_ext;
  logic [N-1:0] count_d;
  logic         at_max;
  logic         at_zero;
  logic         din_bad;
  logic         ovf_d;
  logic         err_d;

  assign count_ext = {1'b0, COUNT};
  assign din_ext   = {1'b0, DIN};
  assign at_max    = (count_ext == MAX_EXT);
  assign at_zero   = (COUNT == '0);
  assign din_bad   = (din_ext > MAX_EXT);

  always_comb begin
    next_ext = count_ext;
    ovf_d    = 1'b0;
    err_d    = 1'b0;
    if (CLR) begin
      next_ext = '0;
    end else if (LD) begin
      if (din_bad) begin
        next_ext = MAX_EXT;
        err_d    = 1'b1;
      end else begin
        next_ext = din_ext;
      end
    end else if (EN) begin
      if (UP) begin
        if (at_max) begin
          ovf_d = 1'b1;
          if (SAT == 0) next_ext = '0;
        end else begin
          next_ext = count_ext + 1'b1;
        end
      end else begin
        if (at_zero) begin
          ovf_d = 1'b1;
          if (SAT == 0) next_ext = MAX_EXT;
        end else begin
          next_ext = count_ext - 1'b1;
        end
      end
    end
  end

  // Guard-bit clamp: the registered count can never leave 0..MOD-1.
  assign count_d = (next_ext > MAX_EXT) ? MAX_EXT[N-1:0] : next_ext[N-1:0];

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      COUNT <= '0;
      OVF   <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      COUNT <= count_d;
      OVF   <= ovf_d;
      ERR   <= err_d;
    end
  end

  assign TC = EN & ~CLR & ~LD & ((UP & at_max) | (~UP & at_zero));

endmodule

// File: tb/tb_cnter_mod_nbit.sv
// Bench for cnter_mod_nbit: wrap, saturate, power-of-two and cascaded instances
// driven by directed vectors; expected {tag,count,tc,ovf,err} go into a queue.
module tb_cnter_mod_nbit;

  localparam int W = 10;

  logic clk;
  logic rst_n;
  logic clr, ld, en, up;
  logic [3:0] din;

  logic [3:0] w_count, s_count, c0_count, c1_count;
  logic [2:0] p_count;
  logic w_tc, w_ovf, w_err;
  logic s_tc, s_ovf, s_err;
  logic p_tc, p_ovf, p_err;
  logic c0_tc, c0_ovf, c0_err;
  logic c1_tc, c1_ovf, c1_err;
  logic c_en;
  logic c_zero;
  logic c_up;
  logic [3:0] c_din;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;
  logic [W-1:0] act_e;
  int checks;
  int errors;

  cnter_mod_nbit #(.N(4), .MOD(10), .SAT(0)) u_wrap (
    .clk(clk), .RESET_N(rst_n), .CLR(clr), .LD(ld), .EN(en), .UP(up), .DIN(din),
    .COUNT(w_count), .TC(w_tc), .OVF(w_ovf), .ERR(w_err)
  );

  cnter_mod_nbit #(.N(4), .MOD(10), .SAT(1)) u_sat (
    .clk(clk), .RESET_N(rst_n), .CLR(clr), .LD(ld), .EN(en), .UP(up), .DIN(din),
    .COUNT(s_count), .TC(s_tc), .OVF(s_ovf), .ERR(s_err)
  );

  cnter_mod_nbit #(.N(3), .MOD(8), .SAT(0)) u_pow2 (
    .clk(clk), .RESET_N(rst_n), .CLR(clr), .LD(ld), .EN(en), .UP(up), .DIN(din[2:0]),
    .COUNT(p_count), .TC(p_tc), .OVF(p_ovf), .ERR(p_err)
  );

  cnter_mod_nbit #(.N(4), .MOD(10), .SAT(0)) u_casc0 (
    .clk(clk), .RESET_N(rst_n), .CLR(c_zero), .LD(c_zero), .EN(c_en), .UP(c_up), .DIN(c_din),
    .COUNT(c0_count), .TC(c0_tc), .OVF(c0_ovf), .ERR(c0_err)
  );

  cnter_mod_nbit #(.N(4), .MOD(10), .SAT(0)) u_casc1 (
    .clk(clk), .RESET_N(rst_n), .CLR(c_zero), .LD(c_zero), .EN(c0_tc), .UP(c_up), .DIN(c_din),
    .COUNT(c1_count), .TC(c1_tc), .OVF(c1_ovf), .ERR(c1_err)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic string tag_name(input logic [2:0] t);
    case (t)
      3'd0:    return "wrap";
      3'd1:    return "sat";
      3'd2:    return "pow2";
      3'd3:    return "casc0";
      default: return "casc1";
    endcase
  endfunction

  // Driver tasks
  task automatic step(input logic c, input logic l, input logic e, input logic u,
                      input logic [3:0] d);
    @(negedge clk);
    clr = c;
    ld  = l;
    en  = e;
    up  = u;
    din = d;
  endtask

  task automatic push(input logic [2:0] tag, input logic [3:0] cnt, input logic tc,
                      input logic ovf, input logic err);
    exp_q.push_back({tag, cnt, tc, ovf, err});
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: compares everything expected for the edge just taken
  always @(posedge clk) begin
    #2;
    while (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      case (exp_e[9:7])
        3'd0:    act_e = {exp_e[9:7], w_count, w_tc, w_ovf, w_err};
        3'd1:    act_e = {exp_e[9:7], s_count, s_tc, s_ovf, s_err};
        3'd2:    act_e = {exp_e[9:7], 1'b0, p_count, p_tc, p_ovf, p_err};
        3'd3:    act_e = {exp_e[9:7], c0_count, c0_tc, c0_ovf, c0_err};
        default: act_e = {exp_e[9:7], c1_count, c1_tc, c1_ovf, c1_err};
      endcase
      checks++;
      if (act_e !== exp_e) begin
        errors++;
        $display("FAIL %s t=%0t actual count=%0d tc=%0b ovf=%0b err=%0b required count=%0d tc=%0b ovf=%0b err=%0b",
                 tag_name(exp_e[9:7]), $time, act_e[6:3], act_e[2], act_e[1], act_e[0],
                 exp_e[6:3], exp_e[2], exp_e[1], exp_e[0]);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clr = 1'b0; ld = 1'b0; en = 1'b1; up = 1'b0; din = 4'd0;
    c_en = 1'b0; c_zero = 1'b0; c_up = 1'b1; c_din = 4'd0;

    // Reset state; TC evaluates with COUNT=0 while reset is held
    #3;
    check("reset_count", w_count, 4'd0);
    check("reset_ovf", {3'b0, w_ovf}, 4'd0);
    check("reset_err", {3'b0, w_err}, 4'd0);
    check("reset_tc_down", {3'b0, w_tc}, 4'd1);
    en = 1'b0;
    #1;
    check("reset_tc_idle", {3'b0, w_tc}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap up 0..9 then 0, TC at 9, OVF only on the wrap
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 1, 1, 0);
      push(3'd0, 4'(k % 10), (k == 9), (k == 10), 1'b0);
    end

    // Wrap down, then direction changes without a turnaround cycle
    step(0, 0, 1, 0, 0);  push(3'd0, 4'd9, 1'b0, 1'b1, 1'b0);
    step(0, 0, 1, 0, 0);  push(3'd0, 4'd8, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1, 1, 0);  push(3'd0, 4'd9, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1, 0, 0);  push(3'd0, 4'd8, 1'b0, 1'b0, 1'b0);

    // Loads: out of range, priority, boundary, back-to-back ERR, CLR clears ERR
    step(0, 1, 0, 0, 12); push(3'd0, 4'd9, 1'b0, 1'b0, 1'b1);
    step(0, 0, 0, 0, 0);  push(3'd0, 4'd9, 1'b0, 1'b0, 1'b0);
    step(1, 1, 1, 1, 3);  push(3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(0, 1, 0, 0, 9);  push(3'd0, 4'd9, 1'b0, 1'b0, 1'b0);
    step(0, 1, 0, 0, 10); push(3'd0, 4'd9, 1'b0, 1'b0, 1'b1);
    step(0, 1, 0, 0, 10); push(3'd0, 4'd9, 1'b0, 1'b0, 1'b1);
    step(0, 1, 0, 0, 15); push(3'd0, 4'd9, 1'b0, 1'b0, 1'b1);
    step(1, 0, 0, 0, 0);  push(3'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Saturating instance at both ends
    step(0, 1, 0, 0, 8);  push(3'd1, 4'd8, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1, 1, 0);  push(3'd1, 4'd9, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1, 1, 0);  push(3'd1, 4'd9, 1'b1, 1'b1, 1'b0);
    step(0, 0, 1, 1, 0);  push(3'd1, 4'd9, 1'b1, 1'b1, 1'b0);
    step(1, 0, 0, 0, 0);  push(3'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1, 0, 0);  push(3'd1, 4'd0, 1'b1, 1'b1, 1'b0);
    step(0, 0, 1, 0, 0);  push(3'd1, 4'd0, 1'b1, 1'b1, 1'b0);
    step(0, 0, 1, 1, 0);  push(3'd1, 4'd1, 1'b0, 1'b0, 1'b0);

    // Power-of-two modulus: full-range load and wraps in both directions
    step(1, 0, 0, 0, 0);  push(3'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    step(0, 1, 0, 0, 7);  push(3'd2, 4'd7, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1, 1, 0);  push(3'd2, 4'd0, 1'b0, 1'b1, 1'b0);
    step(0, 0, 1, 0, 0);  push(3'd2, 4'd7, 1'b0, 1'b1, 1'b0);
    step(0, 0, 1, 1, 0);  push(3'd2, 4'd0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-count
    step(1, 0, 0, 0, 0);  push(3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(0, 1, 0, 0, 5);  push(3'd0, 4'd5, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_count", w_count, 4'd0);
    check("async_ovf", {3'b0, w_ovf}, 4'd0);
    check("async_err", {3'b0, w_err}, 4'd0);
    check("async_tc", {3'b0, w_tc}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(3'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0);  push(3'd0, 4'd1, 1'b0, 1'b0, 1'b0);

    // Two-stage decade cascade, 100 up-edges
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      c_en = 1'b1;
      push(3'd3, 4'(k % 10), (k % 10 == 9), (k % 10 == 0), 1'b0);
      push(3'd4, 4'((k / 10) % 10), (k % 10 == 9) && ((k / 10) % 10 == 9), (k == 100), 1'b0);
    end
    @(negedge clk);
    c_en = 1'b0;
    @(negedge clk);
    @(negedge clk);

    check("queue_drained", 4'(exp_q.size()), 4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnter_mod_nbit.md
CNTER_MOD_NBIT -- requirements
Module: cnter_mod_nbit

Interface
REQ-001 Parameter N, default 4: counter width in bits; legal range 2..16.
REQ-002 Parameter MOD, default 10: count modulus; legal range 2..2^N; count range 0..MOD-1.
REQ-003 Parameter SAT, default 0: 0 = wrap at boundaries, 1 = saturate at boundaries.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 RESET_N  input  1  asynchronous reset, active-low.
REQ-006 CLR  input  1  synchronous clear, active-high.
REQ-007 LD  input  1  synchronous load of DIN, active-high.
REQ-008 EN  input  1  count enable, active-high.
REQ-009 UP  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 DIN  input  N  load value.
REQ-011 COUNT  output  N  registered count value.
REQ-012 TC  output  1  combinational terminal count; usable as EN of a cascaded stage.
REQ-013 OVF  output  1  registered one-cycle pulse: wrap or saturation event occurred on the previous edge.
REQ-014 ERR  output  1  registered one-cycle pulse: out-of-range load occurred on the previous edge.

Function
REQ-015 Per-edge priority: CLR > LD > EN; with none of CLR, LD or EN asserted, COUNT holds.
REQ-016 CLR=1: COUNT <- 0; OVF <- 0; ERR <- 0.
REQ-017 LD=1, CLR=0, DIN <= MOD-1: COUNT <- DIN; ERR <- 0.
REQ-018 LD=1, CLR=0, DIN >= MOD: COUNT <- MOD-1; ERR <- 1 for exactly one cycle.
REQ-019 EN=1, UP=1, COUNT < MOD-1: COUNT <- COUNT+1; OVF <- 0.
REQ-020 EN=1, UP=1, COUNT = MOD-1: SAT=0 -> COUNT <- 0; SAT=1 -> COUNT holds; OVF <- 1 in both modes.
REQ-021 EN=1, UP=0, COUNT > 0: COUNT <- COUNT-1; OVF <- 0.
REQ-022 EN=1, UP=0, COUNT = 0: SAT=0 -> COUNT <- MOD-1; SAT=1 -> COUNT holds at 0; OVF <- 1 in both modes.
REQ-023 TC = EN & ((UP & COUNT==MOD-1) | (~UP & COUNT==0)); TC is forced to 0 while CLR or LD is 1.
REQ-024 OVF and ERR deassert on the next edge after assertion unless the triggering condition repeats; back-to-back events give OVF high on consecutive cycles.
REQ-025 Arithmetic is internal with one guard bit; COUNT never takes a value >= MOD, including for MOD = 2^N.
REQ-026 A change of UP while EN=1 takes effect on the same edge; there is no turnaround cycle.
REQ-027 Latency: COUNT, OVF and ERR update one clock after the qualifying inputs are sampled.
REQ-028 A LD with DIN >= MOD does not assert OVF.
REQ-029 Elaboration fails on an illegal N or MOD parameter value.

Reset
REQ-030 RESET_N=0 forces COUNT=0, OVF=0 and ERR=0 immediately, independent of clk.
REQ-031 Reset asserted mid-count discards the operation in progress; no OVF or ERR pulse is emitted on or after release.
REQ-032 After RESET_N rises, the first rising clk edge is a normal operating edge.
REQ-033 TC is valid during reset and evaluates with COUNT=0.

Verification
REQ-034 Wrap up, N=4 MOD=10 SAT=0: EN=1, UP=1 from 0 for 10 edges -> COUNT 1..9 then 0; TC=1 at COUNT=9; OVF=1 on the cycle COUNT=0 only.
REQ-035 Wrap down, N=4 MOD=10 SAT=0: EN=1, UP=0 from 0 -> COUNT=9, OVF=1; then 8, OVF=0.
REQ-036 Saturate, SAT=1: LD DIN=8, then EN=1, UP=1 for 3 edges -> COUNT 9,9,9; OVF=0,1,1.
REQ-037 Bad load and priority, MOD=10: LD=1 with DIN=12 -> COUNT=9, ERR=1 for one cycle; then CLR=LD=EN=1 together -> COUNT=0, TC=0.
REQ-038 Async reset: COUNT=5 with EN=1, drop RESET_N between edges -> COUNT=0 before the next edge; release -> next edge gives COUNT=1, OVF=0.
REQ-039 Cascade: two instances MOD=10, second EN driven by first TC; 100 up-edges from 0/0 -> 9/9 after 99 edges; both COUNT=0 with both OVF=1 on edge 100.
